// File: rtl/dsp_mac_seq_pkg.sv
// dsp_mac_seq shared types: sequencer states and slice OPMODE codes.
// Imported by the sequencer top and its bench.
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_IDLE  = 8'h00;
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

endpackage

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq job/operand/result handshakes.
// master = requester side, slave = sequencer side.
interface dsp_mac_seq_if #(
  parameter int LEN_W = 8
);

  logic               job_valid;
  logic               job_ready;
  logic [LEN_W-1:0]   job_len;
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s_a;
  logic signed [17:0] s_b;
  logic               r_valid;
  logic               r_ready;
  logic [47:0]        r_data;
  logic               r_carry;

  modport master (
    output job_valid, job_len,
    output s_valid, s_a, s_b,
    output r_ready,
    input  job_ready, s_ready,
    input  r_valid, r_data, r_carry
  );

  modport slave (
    input  job_valid, job_len,
    input  s_valid, s_a, s_b,
    input  r_ready,
    output job_ready, s_ready,
    output r_valid, r_data, r_carry
  );

endinterface

// File: rtl/dsp_mac_skew.sv
// 1-bit delay line of STAGES registers, sync reset.
// Aligns the first-term flag with the slice OPMODE register.
module dsp_mac_skew #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_line
    logic [STAGES-1:0] sr;

    // shift the flag one stage per cycle
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= (sr << 1) | STAGES'(d);
    end

    assign q = sr[STAGES-1];
  end

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences A*B terms through a DSP slice and returns the sum.
// Optional busy-cycle counter: define MAC_SEQ_PERF_EN.
module dsp_mac_seq
  import dsp_mac_seq_pkg::*;
#(
  parameter int P_LAT   = 3,
  parameter int OP_SKEW = 1,
  parameter int LEN_W   = 8
) (
  input  logic        clk,
  input  logic        RST,
  dsp_mac_seq_if.slave bus,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [47:0] dsp_c,
  output logic [17:0] dsp_d,
  output logic        dsp_carryin,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_ce,
  output logic        dsp_rst,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carryout,
  output logic [15:0] busy_cycles
);

  localparam int DW = (P_LAT > 1) ? $clog2(P_LAT) : 1;

  state_t           st;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nx;
  logic [DW-1:0]    dcnt;
  logic             take;
  logic             last;
  logic             first;
  logic             first_d;
  logic             drain_end;
  logic [47:0]      acc_q;
  logic             carry_q;

  assign bus.job_ready = (st == IDLE) && !RST;
  assign bus.s_ready   = (st == ISSUE) && !RST;
  assign bus.r_valid   = (st == DONE) && !RST;
  assign bus.r_data    = acc_q;
  assign bus.r_carry   = carry_q;

  assign take      = bus.s_valid && bus.s_ready;
  assign cnt_nx    = cnt + LEN_W'(1);
  assign last      = take && (cnt_nx == len_q);
  assign first     = take && (cnt == '0);
  assign drain_end = (st == DRAIN) && (dcnt == DW'(P_LAT - 1));

  // idle cycles in ISSUE feed zero operands, i.e. a zero term
  assign dsp_a       = take ? bus.s_a : '0;
  assign dsp_b       = take ? bus.s_b : '0;
  assign dsp_c       = '0;
  assign dsp_d       = '0;
  assign dsp_carryin = 1'b0;
  assign dsp_rst     = RST;
  assign dsp_ce      = ((st == ISSUE) || (st == DRAIN)) && !RST;

  dsp_mac_skew #(
    .STAGES (OP_SKEW)
  ) u_skew (
    .clk (clk),
    .rst (RST),
    .d   (first),
    .q   (first_d)
  );

  // first term restarts the sum, later ones accumulate onto P
  always_comb begin
    dsp_opmode = OPM_IDLE;
    if (dsp_ce) dsp_opmode = first_d ? OPM_FIRST : OPM_ACC;
  end

  // job sequencer: accept, issue terms, wait out slice latency, hold result
  always_ff @(posedge clk) begin
    if (RST) begin
      st      <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      dcnt    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.job_valid) begin
            len_q <= bus.job_len;
            cnt   <= '0;
            if (bus.job_len == '0) begin
              acc_q   <= '0;
              carry_q <= 1'b0;
              st      <= DONE;
            end else begin
              st <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (take) begin
            cnt <= cnt_nx;
            if (last) begin
              dcnt <= '0;
              st   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            acc_q   <= dsp_p;
            carry_q <= dsp_carryout;
            st      <= DONE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          if (bus.r_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] busy_q;

  // count active slice cycles of the current job, saturating
  always_ff @(posedge clk) begin
    if (RST)
      busy_q <= '0;
    else if ((st == IDLE) && bus.job_valid)
      busy_q <= '0;
    else if (dsp_ce && (busy_q != 16'hFFFF))
      busy_q <= busy_q + 16'd1;
  end

  assign busy_cycles = busy_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a registered DSP slice model.
// Define MAC_SEQ_PERF_EN to also check the busy counter.
module tb_dsp_mac_seq;
  import dsp_mac_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic        dsp_carryin, dsp_ce, dsp_rst, dsp_carryout;
  logic [7:0]  dsp_opmode;
  logic [15:0] busy_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  logic ce_seen;

  dsp_mac_seq_if #(.LEN_W(8)) bus ();

  dsp_mac_seq #(
    .P_LAT   (3),
    .OP_SKEW (1),
    .LEN_W   (8)
  ) dut (
    .clk          (clk),
    .RST          (rst),
    .bus          (bus.slave),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_c        (dsp_c),
    .dsp_d        (dsp_d),
    .dsp_carryin  (dsp_carryin),
    .dsp_opmode   (dsp_opmode),
    .dsp_ce       (dsp_ce),
    .dsp_rst      (dsp_rst),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .busy_cycles  (busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slice: A1/B1 -> M -> P, OPMODE registered, common CE and reset
  logic signed [17:0] a1, b1;
  logic signed [35:0] prod;
  logic [47:0]        m_r, p_r;
  logic [7:0]         opm_r;
  logic               co_r;
  logic [48:0]        sum;

  assign prod         = a1 * b1;
  assign sum          = {1'b0, p_r} + {1'b0, m_r};
  assign dsp_p        = p_r;
  assign dsp_carryout = co_r;

  always @(posedge clk) begin
    if (dsp_rst) begin
      a1 <= '0; b1 <= '0; m_r <= '0;
      opm_r <= '0; p_r <= '0; co_r <= 1'b0;
    end else if (dsp_ce) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      m_r   <= {{12{prod[35]}}, prod};
      opm_r <= dsp_opmode;
      if (opm_r == 8'h09) begin
        p_r  <= sum[47:0];
        co_r <= sum[48];
      end else if (opm_r == 8'h01) begin
        p_r  <= m_r;
        co_r <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (dsp_ce) ce_seen = 1'b1;

  task automatic check(input string tag,
                       input logic [47:0] obs,
                       input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] len);
    bus.job_valid = 1'b1;
    bus.job_len   = len;
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic feed(input logic [17:0] a, input logic [17:0] b,
                      input int gap);
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [47:0] exp,
                       input logic [15:0] exp_busy);
    check({tag, ".s_ready_drop"}, 48'(bus.s_ready), 0);
    check({tag, ".ce_drain"}, 48'(dsp_ce), 1);
    @(negedge clk);
    @(negedge clk);
    check({tag, ".rv_early"}, 48'(bus.r_valid), 0);
    @(negedge clk);
    check({tag, ".rv"}, 48'(bus.r_valid), 1);
    check({tag, ".data"}, bus.r_data, exp);
    check({tag, ".carry"}, 48'(bus.r_carry), 0);
    check({tag, ".jr_done"}, 48'(bus.job_ready), 0);
`ifdef MAC_SEQ_PERF_EN
    check({tag, ".busy"}, 48'(busy_cycles), 48'(exp_busy));
`else
    check({tag, ".busy"}, 48'(busy_cycles), 48'(exp_busy & 16'h0));
`endif
  endtask

  task automatic release_res(input string tag);
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    check({tag, ".rv_off"}, 48'(bus.r_valid), 0);
    check({tag, ".jr_back"}, 48'(bus.job_ready), 1);
  endtask

  initial begin
    logic rv_seen;
    rst = 1'b1;
    ce_seen = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.s_valid   = 1'b0;
    bus.s_a       = '0;
    bus.s_b       = '0;
    bus.r_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.job_ready", 48'(bus.job_ready), 0);
    check("rst.s_ready", 48'(bus.s_ready), 0);
    check("rst.r_valid", 48'(bus.r_valid), 0);
    check("rst.r_data", bus.r_data, 0);
    check("rst.r_carry", 48'(bus.r_carry), 0);
    check("rst.ce", 48'(dsp_ce), 0);
    check("rst.opmode", 48'(dsp_opmode), 0);
    check("rst.busy", 48'(busy_cycles), 0);
    check("rst.dsp_rst", 48'(dsp_rst), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle.job_ready", 48'(bus.job_ready), 1);
    check("idle.dsp_rst", 48'(dsp_rst), 0);
    check("idle.dsp_c", dsp_c, 0);

    // three back-to-back terms: 200 + 30 + 1
    start_job(8'd3);
    check("t1.s_ready", 48'(bus.s_ready), 1);
    check("t1.opm_acc0", 48'(dsp_opmode), 48'h09);
    bus.s_valid = 1'b1;
    bus.s_a = 18'd20; bus.s_b = 18'd10;
    @(negedge clk);
    check("t1.opm_first", 48'(dsp_opmode), 48'h01);
    bus.s_a = 18'd5; bus.s_b = 18'd6;
    @(negedge clk);
    check("t1.opm_acc", 48'(dsp_opmode), 48'h09);
    bus.s_a = 18'd1; bus.s_b = 18'd1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    drain("t1", 48'hE7, 16'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1.hold_data", bus.r_data, 48'hE7);
      check("t1.hold_jr", 48'(bus.job_ready), 0);
      check("t1.hold_rv", 48'(bus.r_valid), 1);
    end
    release_res("t1");

    // same job with two bubble cycles between terms
    start_job(8'd3);
    feed(18'd20, 18'd10, 0);
    feed(18'd5, 18'd6, 2);
    feed(18'd1, 18'd1, 2);
    drain("t2", 48'hE7, 16'd10);
    release_res("t2");

    // single negative term: -2 * 3
    start_job(8'd1);
    feed(18'h3FFFE, 18'd3, 0);
    drain("t3", 48'hFFFF_FFFF_FFFA, 16'd4);
    release_res("t3");

    // zero-length job goes straight to DONE
    ce_seen = 1'b0;
    start_job(8'd0);
    check("t4.rv", 48'(bus.r_valid), 1);
    check("t4.data", bus.r_data, 0);
    check("t4.carry", 48'(bus.r_carry), 0);
    check("t4.ce_seen", 48'(ce_seen), 0);

    // job offered with r_ready is taken one cycle later
    bus.r_ready   = 1'b1;
    bus.job_valid = 1'b1;
    bus.job_len   = 8'd1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    check("t5.jr_idle", 48'(bus.job_ready), 1);
    check("t5.rv_off", 48'(bus.r_valid), 0);
    @(negedge clk);
    bus.job_valid = 1'b0;
    check("t5.s_ready", 48'(bus.s_ready), 1);
    feed(18'd7, 18'd8, 0);
    drain("t5", 48'h38, 16'd4);
    release_res("t5");

    // reset in the middle of ISSUE abandons the job
    start_job(8'd3);
    feed(18'd3, 18'd3, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6.s_ready", 48'(bus.s_ready), 0);
    check("t6.dsp_rst", 48'(dsp_rst), 1);
    check("t6.jr_rst", 48'(bus.job_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t6.jr_idle", 48'(bus.job_ready), 1);
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rv_seen = rv_seen | bus.r_valid;
    end
    check("t6.no_result", 48'(rv_seen), 0);

    // recovery after reset
    start_job(8'd1);
    feed(18'd2, 18'd5, 0);
    drain("t7", 48'hA, 16'd4);
    release_res("t7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
